// File: rtl/mem_arb_pkg.sv
// Shared types, func3 codes and the alignment helper for the LSU memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    logic mis;
    case (func3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; purely combinational, last_owner lives in the parent.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant,
  output logic       winner
);

  // A lone request wins; on a tie the requester that did not own last time wins.
  always_comb begin
    winner = 1'b0;
    grant  = 2'b00;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner;
      default: winner = 1'b0;
    endcase
    if (req != 2'b00) grant = winner ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin scheduler between the LSU (r0) and DMA/debug (r1) in front of the
// single-port data memory. One access in flight: IDLE -> ISSUE -> WAIT -> RESP.
// Optional misalignment check: define MEM_ARB_MISALIGN_CHK_EN.
module lsu_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic [2:0]        r0_func3,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [31:0]       r0_rdata,
  output logic              r0_err,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic [2:0]        r1_func3,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [31:0]       r1_rdata,
  output logic              r1_err,

  output logic              mem_load,
  output logic              mem_store,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_byte_address,
  output logic [2:0]        mem_func3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic              last_owner;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        func3_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [1:0]        pick_grant;
  logic              winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_func3;
  logic              sel_mis;
  logic              accept;
  logic              capture;
  logic              resp;

  mem_arb_rr u_rr (
    .req        ({r1_req, r0_req}),
    .last_owner (last_owner),
    .grant      (pick_grant),
    .winner     (winner)
  );

  assign sel_we    = winner ? r1_we    : r0_we;
  assign sel_addr  = winner ? r1_addr  : r0_addr;
  assign sel_wdata = winner ? r1_wdata : r0_wdata;
  assign sel_func3 = winner ? r1_func3 : r0_func3;

`ifdef MEM_ARB_MISALIGN_CHK_EN
  assign sel_mis = is_misaligned(sel_func3, sel_addr[1:0]);
`else
  assign sel_mis = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-state strobes; grants only go out in IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    resp       = 1'b0;
    mem_load   = 1'b0;
    mem_store  = 1'b0;
    r0_gnt     = 1'b0;
    r1_gnt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rst_n && (r0_req || r1_req)) begin
          accept     = 1'b1;
          r0_gnt     = pick_grant[0];
          r1_gnt     = pick_grant[1];
          state_next = sel_mis ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_load   = ~we_q;
        mem_store  = we_q;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        resp       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latency down-counter: loaded during ISSUE, counts to zero in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n)                              cnt <= 4'd0;
    else if (state == ST_ISSUE)              cnt <= 4'(MEM_LAT - 1);
    else if (state == ST_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // Capture the granted request and the memory response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_owner <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      func3_q    <= 3'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        last_owner <= winner;
        owner_q    <= winner;
        we_q       <= sel_we;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        func3_q    <= sel_func3;
        rdata_q    <= 32'd0;
        err_q      <= sel_mis;
      end
      if (capture) rdata_q <= we_q ? 32'd0 : mem_rdata;
    end
  end

  assign mem_addr         = addr_q;
  assign mem_byte_address = addr_q[1:0];
  assign mem_func3        = func3_q;
  assign mem_wdata        = wdata_q;

  assign r0_rvalid = resp & ~owner_q;
  assign r1_rvalid = resp &  owner_q;
  assign r0_rdata  = r0_rvalid ? rdata_q : 32'd0;
  assign r1_rdata  = r1_rvalid ? rdata_q : 32'd0;
  assign r0_err    = r0_rvalid & err_q;
  assign r1_err    = r1_rvalid & err_q;

endmodule

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Two-requester scheduler in front of the single-port data memory and its load/store lane wrapper. It arbitrates between the core load/store unit (requester 0) and a DMA/debug port (requester 1) using round-robin. It sequences each granted access through issue, fixed-latency wait and response phases, then returns read data or store completion to the owning requester. Only one access is outstanding at a time. Memory-side outputs drive the memory's load/store, func3 and byte_address inputs directly.

## Interface
- `MEM_LAT`, default 2: cycles from `mem_en` to valid `mem_rdata`; legal range 1..15.
- `ADDR_W`, default 32: address width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `rN_req`  in  1  request, N = 0 or 1; held high with its fields stable until `rN_gnt`.
- `rN_we`  in  1  1 = store, 0 = load.
- `rN_addr`  in  ADDR_W  byte address.
- `rN_wdata`  in  32  store data.
- `rN_func3`  in  3  RV32 load/store func3.
- `rN_gnt`  out  1  one-cycle accept pulse.
- `rN_rvalid`  out  1  one-cycle completion pulse, for loads and stores.
- `rN_rdata`  out  32  load data, valid with `rN_rvalid`; 0 for stores.
- `rN_err`  out  1  misalignment error, valid with `rN_rvalid`.
- `mem_load`, `mem_store`  out  1  one-cycle access strobes; at most one is high.
- `mem_addr`  out  ADDR_W  captured address.
- `mem_byte_address`  out  2  `mem_addr[1:0]`.
- `mem_func3`  out  3  captured func3.
- `mem_wdata`  out  32  captured store data.
- `mem_rdata`  in  32  extended load data from the lane wrapper.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `rN_req` is high, the picker selects an owner and `gnt` is asserted combinationally in the same cycle. Owner, we, addr, wdata and func3 are registered at that edge. The FSM then moves to ISSUE, or to RESP on a misaligned access when the check is enabled.
- Round-robin: with a single request, that requester wins. With both requesting, the requester that was not `last_owner` wins. `last_owner` updates on every grant.
- ISSUE, one cycle: `mem_load` or `mem_store` is high and all `mem_*` fields hold the captured values. The counter loads `MEM_LAT-1`.
- WAIT: the counter decrements. When it reaches 0, `mem_rdata` is captured (loads) or 0 is captured (stores), and the FSM moves to RESP.
- RESP, one cycle: the owner's `rvalid` is high with `rdata` and `err`. The next state is always IDLE.
- Requests arriving outside IDLE are not granted and wait.
- The non-owner's `rvalid`, `rdata` and `err` stay 0.
- Reset mid-operation: the FSM returns to IDLE and the in-flight access is dropped with no `rvalid`.

## Timing
- Grant at cycle T gives: `mem_*` strobe at T+1, `mem_rdata` sampled at T+1+`MEM_LAT`, `rvalid` at T+2+`MEM_LAT`, next grant possible at T+3+`MEM_LAT`.
- Back-to-back throughput is one access per `MEM_LAT`+3 cycles.
- Reset values:
  - FSM = IDLE, counter = 0, `last_owner` = 1 (r0 wins the first tie).
  - All `gnt`, `rvalid`, `err`, `mem_load` and `mem_store` = 0.
  - All data and address outputs = 0.
- `mem_*` data fields hold their last captured value outside ISSUE; only the strobes are qualified.

## Configuration
- `MEM_ARB_MISALIGN_CHK_EN` defined: at grant, these accesses are misaligned:
  - func3 001/101 with `addr[0]`=1;
  - func3 010 with `addr[1:0]`≠0.
- Misaligned access behaviour: ISSUE and WAIT are skipped and there is no memory strobe. RESP follows at T+1 with `err`=1 and `rdata`=0.
- Undefined: `err` is tied to 0 and every access goes to memory unchanged.

## Structure
- Package `mem_arb_pkg`:
  - state enum;
  - func3 constants `F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101;
  - function `is_misaligned(func3, addr[1:0])`.
- Sub-module `mem_arb_rr`: 2-way round-robin picker with inputs req[1:0] and last_owner, outputs grant one-hot and winner index. It is purely combinational; `last_owner` is registered in the parent.

## Test plan
- `MEM_LAT`=2, r0 load func3=010 addr 0x100, `mem_rdata`=0xDEADBEEF → `r0_gnt` at T, `mem_load` at T+1, `r0_rvalid` at T+4 with `rdata`=0xDEADBEEF, `err`=0.
- Both requesters held for 4 accesses (r0 store, r1 load) → grant order r0, r1, r0, r1, with one grant every 5 cycles; `rvalid` goes only to the owner.
- r1 store func3=000 addr 0x203, `wdata`=0xAB, issued during r0's WAIT → r1 is not granted until r0's RESP has passed; then `mem_store`=1, `mem_byte_address`=3, `mem_func3`=000.
- With `MEM_ARB_MISALIGN_CHK_EN`: r0 load func3=001 addr 0x101 → no `mem_load`, `r0_rvalid` at T+1 with `err`=1, `rdata`=0. Without the macro, the same access issues normally with `err`=0.
- `rst_n` low for one cycle during WAIT → FSM in IDLE, no `rvalid`. A simultaneous r0+r1 request afterwards grants r0 first.
- `MEM_LAT`=1 → `rvalid` at T+3 and back-to-back grants 4 cycles apart.
